// File: rtl/uart_mmio_periph.sv
// UART MMIO peripheral: 8N1 TX/RX with byte FIFOs and programmable divisor.
// Define UART_IRQ_EN to add the IE register at 0x10 and the irq output.
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    // Wrap bit differs and index matches: every slot is occupied.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && !do_push;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module uart_mmio_periph #(
    parameter int          ADDR_W      = 12,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mmio_valid,
    input  logic              mmio_we,
    input  logic [ADDR_W-1:0] mmio_addr,
    input  logic [31:0]       mmio_wdata,
    input  logic [3:0]        mmio_wstrb,
    output logic              mmio_ready,
    output logic [31:0]       mmio_rdata,
    output logic              uart_tx,
`ifdef UART_IRQ_EN
    output logic              irq,
`endif
    input  logic              uart_rx
);
`ifdef UART_IRQ_EN
    localparam int SW = 3;
`else
    localparam int SW = 2;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [SW-1:0] sel;
    logic          rd_req, wr_req;
    logic [15:0]   div;
    logic [31:0]   rdata_d, status;
    logic [2:0]    clr;
    logic          tx_ovf_q, rx_ovf_q, ferr_q;
    logic          unused;

    assign sel    = mmio_addr[SW+1:2];
    assign rd_req = mmio_valid && !mmio_we && mmio_ready;
    assign wr_req = mmio_valid && mmio_we && mmio_ready;
    assign unused = ^{mmio_addr[ADDR_W-1:SW+2], mmio_addr[1:0],
                      mmio_wdata[31:16], mmio_wstrb[3:2]};

    // FIFOs
    logic       tx_push, tx_pop, tx_full, tx_empty, tx_fovf;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_full, rx_empty, rx_fovf;
    logic [7:0] rx_head, rx_sh;

    assign tx_push = wr_req && (sel == SW'(0)) && mmio_wstrb[0];
    assign rx_pop  = rd_req && (sel == SW'(1));

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
        .wdata(mmio_wdata[7:0]), .head(tx_head), .full(tx_full),
        .empty(tx_empty), .ovf(tx_fovf)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
        .wdata(rx_sh), .head(rx_head), .full(rx_full),
        .empty(rx_empty), .ovf(rx_fovf)
    );

    // Transmitter
    tx_state_t   tx_state, tx_state_d;
    logic [15:0] tx_div, tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_q, tx_tick;

    assign tx_tick = (tx_cnt == tx_div);
    assign uart_tx = tx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_pop     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_state_d = TX_START;
                    tx_pop     = 1'b1;
                end
            end
            TX_START: if (tx_tick) tx_state_d = TX_DATA;
            TX_DATA: begin
                if (tx_tick && tx_bit == 3'd7) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_d = tx_empty ? TX_IDLE : TX_START;
                    tx_pop     = !tx_empty;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q   <= 1'b1;
            tx_cnt <= '0;
            tx_div <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
        end else if (tx_pop) begin
            tx_q   <= 1'b0;
            tx_cnt <= '0;
            tx_div <= div;
            tx_bit <= '0;
            tx_sh  <= tx_head;
        end else if (tx_state != TX_IDLE) begin
            if (!tx_tick) begin
                tx_cnt <= tx_cnt + 16'd1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: tx_q <= tx_sh[0];
                    TX_DATA: begin
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            tx_q <= 1'b1;
                        end else begin
                            tx_q  <= tx_sh[1];
                            tx_sh <= tx_sh >> 1;
                        end
                    end
                    default: tx_q <= 1'b1;
                endcase
            end
        end
    end

    // Receiver
    rx_state_t   rx_state, rx_state_d;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_div, rx_cnt;
    logic [2:0]  rx_bit;
    logic        rx_tick, rx_half, rx_ferr;

    assign rx_tick = (rx_cnt == rx_div);
    assign rx_half = (rx_cnt == (rx_div >> 1));

    always_ff @(posedge clk) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_state_d = RX_START;
            RX_START: if (rx_half) rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_tick && rx_bit == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_d = RX_IDLE;
                    rx_push    = rx_s2;
                    rx_ferr    = !rx_s2;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_cnt  <= '0;
            rx_div  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_div <= div;
                end
                RX_START: rx_cnt <= rx_half ? 16'd0 : rx_cnt + 16'd1;
                default: begin
                    if (!rx_tick) begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end else begin
                        rx_cnt <= '0;
                        if (rx_state == RX_DATA) begin
                            rx_sh  <= {rx_s2, rx_sh[7:1]};
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Register file
    assign clr = (wr_req && sel == SW'(2) && mmio_wstrb[0]) ?
                 mmio_wdata[7:5] : 3'b000;

    assign status = {24'h0, ferr_q, rx_ovf_q, tx_ovf_q,
                     tx_state != TX_IDLE, rx_full, !rx_empty,
                     tx_empty, tx_full};

`ifdef UART_IRQ_EN
    logic [2:0] ie;
    logic       any_err;

    assign any_err = ferr_q | rx_ovf_q | tx_ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie  <= '0;
            irq <= 1'b0;
        end else begin
            if (wr_req && sel == SW'(4) && mmio_wstrb[0]) ie <= mmio_wdata[2:0];
            irq <= |(ie & {any_err, tx_empty, !rx_empty});
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        case (sel)
            SW'(1): rdata_d = rx_empty ? 32'h0 : {1'b1, 23'h0, rx_head};
            SW'(2): rdata_d = status;
            SW'(3): rdata_d = {16'h0, div};
`ifdef UART_IRQ_EN
            SW'(4): rdata_d = {29'h0, ie};
`endif
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mmio_ready <= 1'b0;
            mmio_rdata <= '0;
            div        <= DEFAULT_DIV;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            mmio_ready <= 1'b1;
            if (rd_req) mmio_rdata <= rdata_d;
            if (wr_req && sel == SW'(3)) begin
                if (mmio_wstrb[0]) div[7:0]  <= mmio_wdata[7:0];
                if (mmio_wstrb[1]) div[15:8] <= mmio_wdata[15:8];
            end
            // A new event in the same cycle as a clear keeps the bit set.
            tx_ovf_q <= tx_fovf | (tx_ovf_q & ~clr[0]);
            rx_ovf_q <= rx_fovf | (rx_ovf_q & ~clr[1]);
            ferr_q   <= rx_ferr | (ferr_q & ~clr[2]);
        end
    end
endmodule

// File: tb/tb_uart_mmio_periph.sv
// Bench for uart_mmio_periph: register vectors, TX/RX framing,
// FIFO overflow corners and randomized loopback against a queue model.
`timescale 1ns/1ps
module tb_uart_mmio_periph;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mmio_valid, mmio_we;
    logic [11:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic        mmio_ready;
    logic [31:0] mmio_rdata;
    logic        uart_tx, uart_rx;
    logic        loop_en, rx_drv;
`ifdef UART_IRQ_EN
    logic        irq;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;
    assign uart_rx = loop_en ? uart_tx : rx_drv;

    uart_mmio_periph dut (
        .clk(clk), .rst_n(rst_n),
        .mmio_valid(mmio_valid), .mmio_we(mmio_we),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_wstrb(mmio_wstrb), .mmio_ready(mmio_ready),
        .mmio_rdata(mmio_rdata), .uart_tx(uart_tx),
`ifdef UART_IRQ_EN
        .irq(irq),
`endif
        .uart_rx(uart_rx)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; the request is sampled on the next posedge.
    task automatic bus(input logic we, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd);
        mmio_valid = 1'b1;
        mmio_we    = we;
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_wstrb = s;
        @(negedge clk);
        mmio_valid = 1'b0;
        mmio_we    = 1'b0;
        rd = mmio_rdata;
    endtask

    task automatic wait_status(input string name, input logic [31:0] mask,
                               input logic [31:0] val, input int bound);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bound; i++) begin
            bus(1'b0, 12'h008, 32'h0, 4'h0, r);
            if ((r & mask) == val) break;
        end
        chk(name, r & mask, val);
    endtask

    // Drives one frame on rx_drv with 4-clock bits (DIV = 3).
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (4) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vt [14];
    logic [31:0] r, r9, d;
    logic [3:0]  s;
    logic [15:0] div_m;
    logic [7:0]  b, q[$];
    logic        cap [44];
    logic [9:0]  f;
    int          n, dv;

    initial begin
        vt[0]  = '{1'b0, 12'h008, 32'h0,         4'h0, 32'h0000_0002};
        vt[1]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 32'h0000_0363};
        vt[2]  = '{1'b1, 12'h00C, 32'h0000_1234, 4'h3, 32'h0000_0363};
        vt[3]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 32'h0000_1234};
        vt[4]  = '{1'b1, 12'h00C, 32'hFFFF_56AB, 4'h1, 32'h0000_1234};
        vt[5]  = '{1'b0, 12'hF0C, 32'h0,         4'h0, 32'h0000_12AB};
        vt[6]  = '{1'b1, 12'h00C, 32'h0000_7700, 4'hE, 32'h0000_12AB};
        vt[7]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 32'h0000_77AB};
        vt[8]  = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_0000};
        vt[9]  = '{1'b0, 12'h004, 32'h0,         4'h0, 32'h0000_0000};
        vt[10] = '{1'b1, 12'h004, 32'h0000_00FF, 4'hF, 32'h0000_0000};
        vt[11] = '{1'b0, 12'h808, 32'h0,         4'h0, 32'h0000_0002};
        vt[12] = '{1'b1, 12'h00C, 32'h0000_0003, 4'h3, 32'h0000_0002};
        vt[13] = '{1'b0, 12'h00C, 32'h0,         4'h0, 32'h0000_0003};

        rst_n = 1'b0;
        mmio_valid = 1'b0; mmio_we = 1'b0; mmio_addr = '0;
        mmio_wdata = '0; mmio_wstrb = '0;
        loop_en = 1'b0; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'h0, mmio_ready}, 32'h0);
        chk("reset_tx", {31'h0, uart_tx}, 32'h1);
        chk("reset_rdata", mmio_rdata, 32'h0);
`ifdef UART_IRQ_EN
        chk("reset_irq", {31'h0, irq}, 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready", {31'h0, mmio_ready}, 32'h1);

        for (int i = 0; i < 14; i++) begin
            bus(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb, r);
            chk($sformatf("vec%0d", i), r, vt[i].exp);
        end

        div_m = 16'd3;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            s = 4'($urandom);
            bus(1'b1, 12'h00C, d, s, r);
            if (s[0]) div_m[7:0]  = d[7:0];
            if (s[1]) div_m[15:8] = d[15:8];
            bus(1'b0, 12'h00C, 32'h0, 4'h0, r);
            chk("rand_div", r, {16'h0, div_m});
        end
        bus(1'b1, 12'h00C, 32'd3, 4'h3, r);

        // Serial waveform of 0xA5 at 4 clocks per bit.
        bus(1'b1, 12'h000, 32'hA5, 4'h1, r);
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            cap[i] = uart_tx;
        end
        f = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("txbit%0d_lead", k), {31'h0, cap[4*k]}, {31'h0, f[k]});
            chk($sformatf("txbit%0d_tail", k), {31'h0, cap[4*k+3]}, {31'h0, f[k]});
        end
        chk("tx_idle_after", {31'h0, cap[42]}, 32'h1);
        wait_status("tx_done", 32'h13, 32'h02, 50);

        // Loopback of one byte.
        loop_en = 1'b1;
        bus(1'b1, 12'h000, 32'h3C, 4'h1, r);
        repeat (3) @(negedge clk);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("status_busy", r, 32'h12);
        wait_status("lb_idle", 32'h10, 32'h00, 200);
        repeat (8) @(negedge clk);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("status_rx_avail", r, 32'h06);
        bus(1'b0, 12'h004, 32'h0, 4'h0, r);
        chk("rxdata_3c", r, 32'h8000_003C);
        bus(1'b0, 12'h004, 32'h0, 4'h0, r);
        chk("rxdata_empty", r, 32'h0);

        // Randomized loopback bursts against a byte queue.
        for (int rd_i = 0; rd_i < 4; rd_i++) begin
            dv = $urandom_range(3, 9);
            bus(1'b1, 12'h00C, 32'(dv), 4'h3, r);
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                q.push_back(b);
                bus(1'b1, 12'h000, {24'h0, b}, 4'h1, r);
            end
            wait_status("rl_tx_idle", 32'h13, 32'h02, 3000);
            repeat (4 * (dv + 1)) @(negedge clk);
            for (int j = 0; j < n; j++) begin
                bus(1'b0, 12'h004, 32'h0, 4'h0, r);
                chk("rl_rxdata", r, {1'b1, 23'h0, q.pop_front()});
            end
            bus(1'b0, 12'h004, 32'h0, 4'h0, r);
            chk("rl_rx_empty", r, 32'h0);
            bus(1'b0, 12'h008, 32'h0, 4'h0, r);
            chk("rl_status", r, 32'h02);
        end
        bus(1'b1, 12'h00C, 32'd3, 4'h3, r);

        // TX FIFO overflow and sticky clear.
        loop_en = 1'b0;
        for (int i = 0; i < 9; i++) bus(1'b1, 12'h000, 32'(8'h40 + i), 4'h1, r);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("tx_full_no_ovf", r, 32'h11);
        bus(1'b1, 12'h000, 32'hEE, 4'h1, r);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("tx_ovf_set", r, 32'h31);
        bus(1'b1, 12'h008, 32'h20, 4'h1, r);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("tx_ovf_clear", r, 32'h11);
        wait_status("tx_drain", 32'hFF, 32'h02, 1000);

        // Framing error, then a rejected glitch.
        send_rx(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("frame_err", r, 32'h82);
        bus(1'b1, 12'h008, 32'h80, 4'h1, r);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("frame_err_clear", r, 32'h02);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("glitch_status", r, 32'h02);
        bus(1'b0, 12'h004, 32'h0, 4'h0, r);
        chk("glitch_rxdata", r, 32'h0);

        // Fill RX, then pop in the cycle the ninth byte lands.
        q.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_rx(b, 1'b1);
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("rx_full", r, 32'h0E);
        b = 8'($urandom);
        fork
            send_rx(b, 1'b1);
            begin
                repeat (40) @(negedge clk);
                bus(1'b0, 12'h004, 32'h0, 4'h0, r9);
            end
        join
        chk("rx_pop_at_push", r9, {1'b1, 23'h0, q.pop_front()});
        q.push_back(b);
        repeat (4) @(negedge clk);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("rx_full_no_ovf", r, 32'h0E);
        send_rx(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("rx_ovf_set", r, 32'h4E);
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, 12'h004, 32'h0, 4'h0, r);
            chk("rx_drain", r, {1'b1, 23'h0, q.pop_front()});
        end
        bus(1'b0, 12'h004, 32'h0, 4'h0, r);
        chk("rx_drained", r, 32'h0);
        bus(1'b1, 12'h008, 32'h40, 4'h1, r);
        bus(1'b0, 12'h008, 32'h0, 4'h0, r);
        chk("rx_ovf_clear", r, 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_mmio_periph.md
Name: uart_mmio_periph

Overview:
- UART peripheral behind the SoC MMIO interconnect; slave on the `uart_mmio` channel, decoded at UART_BASE (4 KiB window).
- 8N1 transmitter and receiver, each with a FIFO, plus a programmable baud divisor.
- Register file is 32-bit. Read data is registered: it is presented the cycle after the request and held until the next read, matching the interconnect's next-cycle load response.

Parameters:
- ADDR_W, 12, MMIO offset width (matches interconnect ADDR_W).
- FIFO_DEPTH, 8, entries per TX and RX FIFO; power of two, ≥2.
- DEFAULT_DIV, 16'd867, reset value of DIV (100 MHz / 115200 − 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- mmio_valid  in  1  request strobe, one cycle per access
- mmio_we  in  1  1 = write, 0 = read
- mmio_addr  in  ADDR_W  byte offset; [3:2] selects register, other bits ignored (aliasing)
- mmio_wdata  in  32  write data
- mmio_wstrb  in  4  byte enables
- mmio_ready  out  1  always 1 out of reset
- mmio_rdata  out  32  registered read data
- uart_tx  out  1  serial out, idle high
- uart_rx  in  1  serial in, asynchronous
- irq  out  1  only when UART_IRQ_EN is defined

Behaviour:
- Reset is synchronous and active-low on rst_n, clock clk. Reset values:
  - mmio_rdata = 0, uart_tx = 1, irq = 0.
  - FIFOs empty, sticky bits 0, DIV = DEFAULT_DIV, both FSMs IDLE.
- mmio_ready = 1 out of reset; held 0 while rst_n = 0.
- Register map, offset [3:2]:
  - 0x0 TXDATA (W): on write with wstrb[0], push wdata[7:0] to the TX FIFO. Reads return 0.
  - 0x4 RXDATA (R): returns {RX_VALID, 23'b0, byte}. If RX is non-empty, returns the head and pops it. If empty, returns 0 and pops nothing. Writes ignored.
  - 0x8 STATUS:
    - Bits: [0] TX_FULL, [1] TX_EMPTY, [2] RX_AVAIL, [3] RX_FULL, [4] TX_BUSY, [5] TX_OVF, [6] RX_OVF, [7] FRAME_ERR. Bits [5..7] are sticky.
    - Writing 1 to bits [7:5] (with wstrb[0]) clears them.
  - 0xC DIV: bits [15:0], byte-lane writes per wstrb[1:0]; upper bits read 0.
- Read latency: rdata updates at the clock edge ending the valid && !we cycle. It is stable thereafter until the next read; writes do not change rdata.
- Bit period is DIV+1 clocks. A DIV change takes effect at the next frame start; a frame in progress keeps its latched divisor.
- TX FSM, IDLE → START → DATA(8, LSB first) → STOP → IDLE:
  - Leaves IDLE the cycle after the FIFO becomes non-empty; pops the head on IDLE→START.
  - Back-to-back frames: STOP goes directly to START if the FIFO is non-empty.
  - TX_BUSY = (state != IDLE).
- TX FIFO full on write: byte dropped, TX_OVF set. If the FSM pops in the same cycle, the push is accepted.
- RX path:
  - uart_rx passes through a 2-flop synchronizer; start is a falling edge seen in IDLE.
  - Start is re-checked at the half period (DIV>>1); if high, return to IDLE (glitch rejected).
  - Data bits are sampled mid-bit, LSB first.
  - Stop bit sampled low: FRAME_ERR set, byte discarded.
  - RX FSM states: IDLE → START → DATA → STOP → IDLE.
- RX FIFO full on push: byte dropped, RX_OVF set. A CPU pop and RX push in the same cycle with the FIFO full: pop first, push accepted, no overflow.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; the wrap bit distinguishes full from empty.
- Unmapped behaviour: none; all four offsets are decoded and upper address bits alias.

Optional Feature:
- Macro `UART_IRQ_EN`.
- Defined:
  - Adds the irq port and the IE register at offset 0x10 (decode widens to [4:2]; 0x14–0x1C read 0).
  - IE bits: [0] RX_AVAIL enable, [1] TX_EMPTY enable, [2] error (any sticky) enable.
  - irq = OR of enabled conditions, registered (one-cycle latency); reset 0.
- Undefined: no irq port, no IE register; decode uses [3:2] only.

Test Plan:
- Reset then read STATUS → rdata = 0x0000_0002 the next cycle. Read DIV → 0x0000_0363. uart_tx = 1.
- DIV=3, write TXDATA=0xA5:
  - uart_tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 clocks wide.
  - TX_BUSY is 1 during the frame; TX_EMPTY returns to 1 after it.
- DIV=3, loop uart_tx→uart_rx, write 0x3C, wait for RX_AVAIL:
  - Read RXDATA → 0x8000_003C.
  - Read again → 0x0000_0000.
- Write 9 bytes back-to-back with DIV=3, FIFO_DEPTH=8:
  - First is popped to the shifter, so 8 are queued and none lost.
  - Write 1 more → TX_OVF=1.
  - Write STATUS 0x20 → TX_OVF=0.
- Drive uart_rx frame 0x55 with stop bit 0 → FRAME_ERR=1, RX_AVAIL=0. A 1-clock low glitch on idle uart_rx → no byte, no error.
- Fill RX to 8 entries, then read RXDATA in the same cycle the 9th byte completes → no RX_OVF, RX_FULL stays 1.
